// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter: FSM states, port indices, default widths.
package mem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam logic PORT_D = 1'b0;
  localparam logic PORT_I = 1'b1;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational arbiter: round-robin on last_owner, or fixed D priority when prio_mode=1.
// Zero latency; a lone requester always wins, grant is one-hot or zero.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  input  logic       prio_mode,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req[PORT_D] && req[PORT_I]) begin
      if (prio_mode || (last_owner == PORT_I)) begin
        gnt[PORT_D] = 1'b1;
      end else begin
        gnt[PORT_I] = 1'b1;
      end
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates data and fetch ports onto one single-ported memory; write done at accept+2, read done at accept+RD_LATENCY+1.
// Grants only in IDLE; requesters hold their request until granted, so waiting requests are re-arbitrated on return to IDLE.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RD_LATENCY = 1,
  parameter int DATA_PRIO  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] read_data
);

  localparam int             CNT_W    = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LATENCY - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                owner_q, owner_d;
  logic                last_owner_q, last_owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                d_done_q, d_done_d;
  logic                i_done_q, i_done_d;
  logic [1:0]          arb_gnt;
  logic                idle;

  assign idle = (state_q == IDLE);

  rr_arb2 u_arb (
    .req        ({i_req, d_req}),
    .last_owner (last_owner_q),
    .prio_mode  (DATA_PRIO != 0),
    .gnt        (arb_gnt)
  );

  // Grants are gated by rst_n so they read 0 the instant reset asserts, even with requests held.
  assign d_gnt      = rst_n && idle && arb_gnt[PORT_D];
  assign i_gnt      = rst_n && idle && arb_gnt[PORT_I];
  assign d_done     = d_done_q;
  assign i_done     = i_done_q;
  assign rdata      = rdata_q;
  assign address    = addr_q;
  assign write_data = wdata_q;
  assign MemWrite   = !idle && we_q;
  assign MemRead    = !idle && !we_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    d_done_d     = 1'b0;
    i_done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_gnt || i_gnt) begin
          owner_d      = d_gnt ? PORT_D : PORT_I;
          last_owner_d = owner_d;
          we_d         = d_gnt ? d_we : 1'b0;
          addr_d       = d_gnt ? d_addr : i_addr;
          wdata_d      = d_gnt ? d_wdata : wdata_q;
          cnt_d        = '0;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q || (cnt_q == CNT_LAST)) begin
          if (!we_q) begin
            rdata_d = read_data;
          end
          state_d  = IDLE;
          d_done_d = (owner_q == PORT_D);
          i_done_d = (owner_q == PORT_I);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= PORT_I;
      last_owner_q <= PORT_I;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      d_done_q     <= 1'b0;
      i_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      d_done_q     <= d_done_d;
      i_done_q     <= i_done_d;
    end
  end

endmodule
